// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Four-state sequencer (IDLE/DECODE/EXEC/WB) driving an external
//            register file and ALU, with branch, store and flag handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [1:0]    rf_raddr_a,
    output logic [1:0]    rf_raddr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
    output logic [2:0]    alu_cmd,
    output logic [1:0]    sel_cmd,
    output logic [DW-1:0] alu_inA,
    output logic [DW-1:0] alu_inB,
    output logic          alu_sc_i,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_sc_o,
    input  logic          alu_zero,
    input  logic          alu_pari,
    output logic          rf_we,
    output logic [1:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] pc,
    output logic          br_taken,
    output logic          done,
    output logic          illegal,
    output logic [2:0]    flags
);

    localparam logic [2:0] c_OP_SYS  = 3'b000;
    localparam logic [2:0] c_OP_BZ   = 3'b001;
    localparam logic [2:0] c_OP_C101 = 3'b101;
    localparam logic [2:0] c_OP_SLL  = 3'b110;
    localparam logic [2:0] c_OP_JMP  = 3'b111;
    localparam logic [1:0] c_SEL_STR = 2'b01;
    localparam logic [1:0] c_SEL_ILL = 2'b11;
    localparam logic [DW-1:0] c_PC_STEP = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [8:0]    r_instr;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [DW-1:0] r_rslt;
    logic          r_res_zero;
    logic          r_res_pari;
    logic          r_res_sc;
    logic          r_br_taken;
    logic [DW-1:0] r_pc;
    logic [2:0]    r_flags;   // {carry, parity, zero}

    logic [2:0]    w_op;
    logic [1:0]    w_sel;
    logic [1:0]    w_ra;
    logic [1:0]    w_rb;
    logic [DW-1:0] w_off_ext;
    logic          w_is_branch;
    logic          w_is_illegal;
    logic          w_is_store;
    logic          w_is_rf_write;
    logic          w_wb_active;

    assign w_op      = r_instr[8:6];
    assign w_sel     = r_instr[5:4];
    assign w_ra      = r_instr[3:2];
    assign w_rb      = r_instr[1:0];
    assign w_off_ext = {{(DW-6){r_instr[5]}}, r_instr[5:0]};

    assign w_is_branch   = (w_op == c_OP_BZ) || (w_op == c_OP_JMP);
    assign w_is_illegal  = (w_op == c_OP_SYS) && (w_sel == c_SEL_ILL);
    assign w_is_store    = (w_op == c_OP_SYS) && (w_sel == c_SEL_STR);
    assign w_is_rf_write = ((w_op != c_OP_SYS) && !w_is_branch) ||
                           ((w_op == c_OP_SYS) && !w_sel[0]);

    // A reset arriving during WB must suppress that cycle's write strobes.
    assign w_wb_active = (r_state == S_WB) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        alu_cmd     = 3'b000;
        sel_cmd     = 2'b00;
        alu_inA     = '0;
        alu_inB     = '0;
        alu_sc_i    = 1'b0;
        rf_we       = 1'b0;
        mem_we      = 1'b0;
        br_taken    = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
                alu_cmd     = w_op;
                sel_cmd     = w_sel;
                alu_inA     = r_op_a;
                alu_inB     = r_op_b;
                alu_sc_i    = r_flags[2];
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
                rf_we       = w_wb_active && w_is_rf_write;
                mem_we      = w_wb_active && w_is_store;
                br_taken    = w_wb_active && r_br_taken;
                illegal     = w_wb_active && w_is_illegal;
                done        = w_wb_active;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rslt     <= '0;
            r_res_zero <= 1'b0;
            r_res_pari <= 1'b0;
            r_res_sc   <= 1'b0;
            r_br_taken <= 1'b0;
            r_pc       <= '0;
            r_flags    <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                    end
                end
                S_DECODE: begin
                    r_op_a <= rf_rdata_a;
                    r_op_b <= rf_rdata_b;
                end
                S_EXEC: begin
                    r_rslt     <= alu_rslt;
                    r_res_zero <= alu_zero;
                    r_res_pari <= alu_pari;
                    r_res_sc   <= alu_sc_o;
                    // Conditional branch looks at the zero flag as it stands in EXEC.
                    r_br_taken <= (w_op == c_OP_JMP) ||
                                  ((w_op == c_OP_BZ) && r_flags[0]);
                end
                S_WB: begin
                    r_pc <= r_pc + (r_br_taken ? w_off_ext : c_PC_STEP);
                    if (!w_is_branch && !w_is_illegal) begin
                        r_flags[0] <= r_res_zero;
                        r_flags[1] <= r_res_pari;
                    end
                    if ((w_op == c_OP_C101) || (w_op == c_OP_SLL)) begin
                        r_flags[2] <= r_res_sc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_raddr_a = w_ra;
    assign rf_raddr_b = w_rb;
    assign rf_waddr   = w_ra;
    assign rf_wdata   = r_rslt;
    assign mem_addr   = r_op_a;
    assign mem_wdata  = r_rslt;
    assign pc         = r_pc;
    assign flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq with a modelled
//            register file and a bench-driven ALU response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] rf_raddr_a, rf_raddr_b;
    logic [7:0] rf_rdata_a, rf_rdata_b;
    logic [2:0] alu_cmd;
    logic [1:0] sel_cmd;
    logic [7:0] alu_inA, alu_inB;
    logic       alu_sc_i;
    logic [7:0] alu_rslt;
    logic       alu_sc_o, alu_zero, alu_pari;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] pc;
    logic       br_taken, done, illegal;
    logic [2:0] flags;

    logic [7:0] rf [4];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    alu_seq #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_cmd(alu_cmd),
        .sel_cmd(sel_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_zero(alu_zero),
        .alu_pari(alu_pari), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc),
        .br_taken(br_taken), .done(done), .illegal(illegal), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [7:0] r, input logic sc, input logic z, input logic p);
        alu_rslt = r;
        alu_sc_o = sc;
        alu_zero = z;
        alu_pari = p;
    endtask

    // Present an instruction in IDLE; returns one step after the accepting edge (DECODE).
    task automatic accept(input logic [8:0] ins);
        int g;
        g = 0;
        while (!instr_ready && g < 10) begin
            tick();
            g++;
        end
        chk("accept_ready", 32'(instr_ready), 1);
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] sel,
                                      input logic [1:0] ra, input logic [1:0] rb);
        return {op, sel, ra, rb};
    endfunction

    function automatic logic [8:0] br(input logic [2:0] op, input logic [5:0] off);
        return {op, off};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        set_alu(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_ready",   32'(instr_ready), 1);
        chk("rst_pc",      32'(pc),          0);
        chk("rst_flags",   32'(flags),       0);
        chk("rst_rf_we",   32'(rf_we),       0);
        chk("rst_mem_we",  32'(mem_we),      0);
        chk("rst_done",    32'(done),        0);
        chk("rst_illegal", 32'(illegal),     0);
        chk("rst_br",      32'(br_taken),    0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready",  32'(instr_ready), 1);

        // XOR r1 ^ r2, with a stray valid instruction while busy
        rf[1] = 8'h5A;
        rf[2] = 8'h5A;
        set_alu(8'h00, 1'b0, 1'b1, 1'b0);
        accept(mk(3'b011, 2'b00, 2'd1, 2'd2));
        chk("xor_dec_ra",    32'(rf_raddr_a),  1);
        chk("xor_dec_rb",    32'(rf_raddr_b),  2);
        chk("xor_dec_ready", 32'(instr_ready), 0);
        chk("xor_dec_cmd",   32'(alu_cmd),     0);
        chk("xor_dec_inA",   32'(alu_inA),     0);
        instr       = br(3'b111, 6'h10);
        instr_valid = 1'b1;
        tick();
        chk("xor_ex_cmd",  32'(alu_cmd),  3);
        chk("xor_ex_sel",  32'(sel_cmd),  0);
        chk("xor_ex_inA",  32'(alu_inA),  'h5A);
        chk("xor_ex_inB",  32'(alu_inB),  'h5A);
        chk("xor_ex_sci",  32'(alu_sc_i), 0);
        tick();
        instr_valid = 1'b0;
        chk("xor_wb_we",    32'(rf_we),    1);
        chk("xor_wb_waddr", 32'(rf_waddr), 1);
        chk("xor_wb_wdata", 32'(rf_wdata), 0);
        chk("xor_wb_mem",   32'(mem_we),   0);
        chk("xor_wb_done",  32'(done),     1);
        chk("xor_wb_br",    32'(br_taken), 0);
        tick();
        chk("xor_pc",    32'(pc),          1);
        chk("xor_flags", 32'(flags),       'b001);
        chk("xor_done0", 32'(done),        0);
        chk("xor_ready", 32'(instr_ready), 1);

        // SLL producing carry
        set_alu(8'h00, 1'b1, 1'b1, 1'b0);
        accept(mk(3'b110, 2'b00, 2'd2, 2'd3));
        tick();
        chk("sll_ex_cmd", 32'(alu_cmd), 6);
        tick();
        chk("sll_wb_we",    32'(rf_we),    1);
        chk("sll_wb_waddr", 32'(rf_waddr), 2);
        tick();
        chk("sll_flags", 32'(flags), 'b101);
        chk("sll_pc",    32'(pc),    2);

        // OR must keep carry
        set_alu(8'h81, 1'b0, 1'b0, 1'b1);
        accept(mk(3'b100, 2'b00, 2'd1, 2'd2));
        tick();
        chk("or_ex_sci", 32'(alu_sc_i), 1);
        tick();
        chk("or_wb_wdata", 32'(rf_wdata), 'h81);
        tick();
        chk("or_flags", 32'(flags), 'b110);
        chk("or_pc",    32'(pc),    3);

        // Unconditional branch +13 -> pc 0x10; ALU flags must be ignored
        set_alu(8'h00, 1'b1, 1'b1, 1'b0);
        accept(br(3'b111, 6'h0D));
        tick();
        tick();
        chk("jmp_wb_br",   32'(br_taken), 1);
        chk("jmp_wb_we",   32'(rf_we),    0);
        chk("jmp_wb_mem",  32'(mem_we),   0);
        chk("jmp_wb_done", 32'(done),     1);
        tick();
        chk("jmp_pc",    32'(pc),    'h10);
        chk("jmp_flags", 32'(flags), 'b110);

        // Conditional branch with zero=0: not taken
        accept(br(3'b001, 6'h3E));
        tick();
        tick();
        chk("bz_nt_br",   32'(br_taken), 0);
        chk("bz_nt_done", 32'(done),     1);
        tick();
        chk("bz_nt_pc",    32'(pc),    'h11);
        chk("bz_nt_flags", 32'(flags), 'b110);

        // Branch -19 to 0xFE, then +3 wraps to 0x01
        accept(br(3'b111, 6'h2D));
        tick();
        tick();
        tick();
        chk("jmp_back_pc", 32'(pc), 'hFE);
        accept(br(3'b111, 6'h03));
        tick();
        tick();
        chk("wrap_wb_br",  32'(br_taken), 1);
        chk("wrap_wb_we",  32'(rf_we),    0);
        chk("wrap_wb_mem", 32'(mem_we),   0);
        tick();
        chk("wrap_pc", 32'(pc), 'h01);

        // Store: mem[r0] <= result
        rf[0] = 8'h20;
        rf[3] = 8'h77;
        set_alu(8'h77, 1'b0, 1'b0, 1'b0);
        accept(mk(3'b000, 2'b01, 2'd0, 2'd3));
        tick();
        chk("str_ex_sel", 32'(sel_cmd), 1);
        chk("str_ex_inA", 32'(alu_inA), 'h20);
        chk("str_ex_inB", 32'(alu_inB), 'h77);
        tick();
        chk("str_wb_mem",   32'(mem_we),    1);
        chk("str_wb_addr",  32'(mem_addr),  'h20);
        chk("str_wb_wdata", 32'(mem_wdata), 'h77);
        chk("str_wb_rfwe",  32'(rf_we),     0);
        tick();
        chk("str_pc",    32'(pc),    2);
        chk("str_flags", 32'(flags), 'b100);

        // ADD giving zero, then a taken conditional branch
        set_alu(8'h00, 1'b0, 1'b1, 1'b1);
        accept(mk(3'b010, 2'b00, 2'd1, 2'd2));
        tick();
        tick();
        tick();
        chk("add_flags", 32'(flags), 'b111);
        chk("add_pc",    32'(pc),    3);
        accept(br(3'b001, 6'h05));
        tick();
        tick();
        chk("bz_t_br", 32'(br_taken), 1);
        tick();
        chk("bz_t_pc", 32'(pc), 8);

        // Illegal instruction
        set_alu(8'h55, 1'b1, 1'b0, 1'b0);
        accept(mk(3'b000, 2'b11, 2'd1, 2'd2));
        tick();
        tick();
        chk("ill_wb_ill",  32'(illegal), 1);
        chk("ill_wb_we",   32'(rf_we),   0);
        chk("ill_wb_mem",  32'(mem_we),  0);
        chk("ill_wb_done", 32'(done),    1);
        tick();
        chk("ill_clear", 32'(illegal), 0);
        chk("ill_flags", 32'(flags),   'b111);
        chk("ill_pc",    32'(pc),      9);

        // Reset during EXEC aborts the instruction
        set_alu(8'hAA, 1'b0, 1'b0, 1'b0);
        accept(mk(3'b011, 2'b00, 2'd1, 2'd2));
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_done",  32'(done),        0);
        chk("abort_we",    32'(rf_we),       0);
        chk("abort_pc",    32'(pc),          0);
        chk("abort_flags", 32'(flags),       0);
        chk("abort_ready", 32'(instr_ready), 1);
        rst_n = 1'b1;
        tick();
        chk("post_done",  32'(done),        0);
        chk("post_we",    32'(rf_we),       0);
        chk("post_ready", 32'(instr_ready), 1);
        chk("post_pc",    32'(pc),          0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DW, default 8, datapath width; all 8-bit ports below are DW wide.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port instr  input  9  instruction: [8:6] op, [5:4] sel, [3:2] ra, [1:0] rb; for branches [5:0] is a signed offset.
REQ-005 SHALL have port instr_valid  input  1  instr is valid.
REQ-006 SHALL have port instr_ready  output  1  block accepts instr.
REQ-007 SHALL have port rf_raddr_a / rf_raddr_b  output  2 each  register-file read addresses (ra, rb).
REQ-008 SHALL have port rf_rdata_a / rf_rdata_b  input  8 each  combinational register-file read data.
REQ-009 SHALL have port alu_cmd  output  3  ALU opcode.
REQ-010 SHALL have port sel_cmd  output  2  ALU sub-select.
REQ-011 SHALL have port alu_inA / alu_inB  output  8 each  ALU operands.
REQ-012 SHALL have port alu_sc_i  output  1  ALU shift-carry in.
REQ-013 SHALL have ports alu_rslt (8), alu_sc_o, alu_zero and alu_pari (1 each)  input  combinational ALU outputs.
REQ-014 SHALL have ports rf_we (1), rf_waddr (2) and rf_wdata (8)  output  register-file write.
REQ-015 SHALL have ports mem_we (1), mem_addr (8) and mem_wdata (8)  output  data-memory write.
REQ-016 SHALL have ports pc  output  8  program counter; br_taken  output  1  one-cycle taken-branch pulse.
REQ-017 SHALL have ports done and illegal  output  1 each  one-cycle retire pulse and illegal-instruction pulse.
REQ-018 SHALL have port flags  output  3  {carry, parity, zero}.

Function
REQ-019 SHALL implement an FSM with states IDLE -> DECODE -> EXEC -> WB -> IDLE, one cycle each except IDLE.
REQ-020 SHALL assert instr_ready only in IDLE; instr SHALL be latched on the edge where instr_valid && instr_ready, and IDLE SHALL be left on that edge.
REQ-021 In DECODE, SHALL drive rf_raddr_a=ra and rf_raddr_b=rb, and SHALL latch rf_rdata_a/b into opA/opB at the end of the cycle.
REQ-022 In EXEC, SHALL drive alu_cmd=op, sel_cmd=sel, alu_inA=opA, alu_inB=opB and alu_sc_i=carry, and SHALL latch alu_rslt, alu_zero, alu_pari and alu_sc_o at the end of the cycle.
REQ-023 Outside EXEC, SHALL drive alu_cmd=000, sel_cmd=00, alu_inA=0, alu_inB=0 and alu_sc_i=0.
REQ-024 In WB, for op 010/011/100/101/110, and for op 000 with sel 00 or 10, SHALL pulse rf_we=1 with rf_waddr=ra and rf_wdata=latched result.
REQ-025 In WB, for op 000 with sel 01 (STR), SHALL pulse mem_we=1 with mem_addr=opA and mem_wdata=latched result; rf_we SHALL stay 0.
REQ-026 For op 000 with sel 11, SHALL pulse illegal=1 in WB, perform no write, leave flags unchanged, and advance pc by 1.
REQ-027 For non-branch, non-illegal instructions, SHALL update zero and parity from the latched ALU flags.
REQ-028 SHALL update carry only for op 101/110 (from latched alu_sc_o); all other ops SHALL leave carry unchanged.
REQ-029 Op 001 SHALL branch taken iff the zero flag is 1 at EXEC; op 111 SHALL always branch taken; branches SHALL not write and SHALL not alter flags.
REQ-030 In WB, SHALL set pc = pc + sext(instr[5:0]) if the branch is taken (pulsing br_taken), otherwise pc = pc + 1; arithmetic is mod 256 (wraps).
REQ-031 SHALL pulse done exactly once per instruction, in WB.
REQ-032 Latency: accept at edge N; WB is active in the cycle after edge N+2; instr_ready SHALL return at edge N+3, giving a maximum throughput of one instruction per 4 cycles.
REQ-033 SHALL ignore instr_valid outside IDLE; instr SHALL have no effect unless accepted.

Reset
REQ-034 When rst_n=0 at a rising edge, SHALL enter IDLE and clear pc, flags, opA, opB and the latched result to 0.
REQ-035 After reset, SHALL hold rf_we, mem_we, br_taken, done and illegal at 0, with instr_ready=1 in the cycle following.
REQ-036 Reset asserted in DECODE, EXEC or WB SHALL abort the instruction with no write, no pc change and no done pulse.

Verification
REQ-037 Reset then XOR (op 011, ra=1, rb=2), r1=0x5A, r2=0x5A -> WB: rf_we=1, waddr=1, wdata=0x00, zero=1, parity=0, pc=1, done 3 cycles after accept.
REQ-038 SLL (op 110) with ALU returning rslt=0x00 and sc_o=1 -> carry=1; a following OR instruction leaves carry=1.
REQ-039 pc=0xFE, op 111 with offset 6'h03 -> pc=0x01 (wrap), br_taken=1, no rf_we/mem_we.
REQ-040 zero=0, op 001 with offset 6'h3E (-2) at pc=0x10 -> not taken, pc=0x11, br_taken=0.
REQ-041 STR (op 000 sel 01), r0=0x20, r3=0x77 with ALU rslt=0x77 -> mem_we=1, mem_addr=0x20, mem_wdata=0x77, rf_we=0.
REQ-042 Illegal (op 000 sel 11), and a separate instruction with rst_n=0 during EXEC -> illegal pulse, flags unchanged, pc+1; the reset case gives no done, pc=0 and instr_ready=1 next cycle.
